// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit path: size defaults, frame length and channel codes.
package i2s_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int SLOT_W_DEF   = 32;
    localparam int TPS_DEF      = 4;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    function automatic int frame_ticks(input int slot_w, input int tps);
        return 2 * slot_w * tps;
    endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// Frame timebase: tick counter, registered mclk/sclk/lrck pins and the strobes that pace the shifter.
module i2s_frame_timer
    import i2s_pkg::*;
#(
    parameter int SLOT_W = SLOT_W_DEF,
    parameter int TPS    = TPS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic mclk_tick,
    output logic i2s_mclk,
    output logic i2s_sclk,
    output logic i2s_lrck,
    output logic load_slot,
    output logic shift_en,
    output logic frame_wrap,
    output logic slot_ch
);

    localparam int FT = frame_ticks(SLOT_W, TPS);
    localparam int TW = $clog2(FT);

    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nx;
    int            t_nx;

    // Strobes describe the edge about to happen, so the shifter updates with the pins.
    always_comb begin
        tcnt_nx    = (tcnt == TW'(FT - 1)) ? '0 : tcnt + TW'(1);
        t_nx       = int'(tcnt_nx);
        frame_wrap = mclk_tick && (tcnt == TW'(FT - 1));
        shift_en   = mclk_tick && ((t_nx % TPS) == 0);
        load_slot  = shift_en && (((t_nx / TPS) % SLOT_W) == 0);
        slot_ch    = (t_nx >= FT / 2) ? CH_RIGHT : CH_LEFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt     <= '0;
            i2s_mclk <= 1'b0;
            i2s_sclk <= 1'b0;
            i2s_lrck <= 1'b0;
        end else if (mclk_tick) begin
            tcnt     <= tcnt_nx;
            i2s_mclk <= ~i2s_mclk;
            i2s_sclk <= (t_nx % TPS) >= (TPS / 2);
            i2s_lrck <= slot_ch;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep holding buffer with valid/ready intake, per-frame sample latch and slot shifter.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int SLOT_W   = SLOT_W_DEF,
    parameter int TPS      = TPS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mclk_tick,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                s_ready,
    output logic                i2s_mclk,
    output logic                i2s_sclk,
    output logic                i2s_lrck,
    output logic                i2s_sdata,
    output logic                frame_start,
    output logic                underrun
);

    logic                load_slot;
    logic                shift_en;
    logic                frame_wrap;
    logic                slot_ch;
    logic                accept;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic [SAMPLE_W-1:0] act_l, act_r;
    logic [SAMPLE_W-1:0] next_l, next_r;
    logic [SAMPLE_W-1:0] load_val;
    logic [SAMPLE_W-1:0] shreg;

    i2s_frame_timer #(
        .SLOT_W (SLOT_W),
        .TPS    (TPS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .mclk_tick  (mclk_tick),
        .i2s_mclk   (i2s_mclk),
        .i2s_sclk   (i2s_sclk),
        .i2s_lrck   (i2s_lrck),
        .load_slot  (load_slot),
        .shift_en   (shift_en),
        .frame_wrap (frame_wrap),
        .slot_ch    (slot_ch)
    );

    // The left load coincides with the wrap, so it takes the freshly latched pair directly.
    always_comb begin
        accept   = s_valid && s_ready;
        next_l   = hold_full ? hold_l : '0;
        next_r   = hold_full ? hold_r : '0;
        load_val = frame_wrap ? next_l : ((slot_ch == CH_RIGHT) ? act_r : act_l);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            act_l       <= '0;
            act_r       <= '0;
            shreg       <= '0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            s_ready     <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            underrun    <= frame_wrap && !hold_full;
            if (frame_wrap) begin
                act_l <= next_l;
                act_r <= next_r;
            end
            // Bit 0 of each slot is the I2S one-bit delay; the MSB follows on the next shift.
            if (load_slot) begin
                shreg     <= load_val;
                i2s_sdata <= 1'b0;
            end else if (shift_en) begin
                i2s_sdata <= shreg[SAMPLE_W-1];
                shreg     <= {shreg[SAMPLE_W-2:0], 1'b0};
            end
            if (accept) begin
                hold_full <= 1'b1;
                hold_l    <= s_left;
                hold_r    <= s_right;
            end else if (frame_wrap) begin
                hold_full <= 1'b0;
            end
            s_ready <= !(accept || (hold_full && !frame_wrap));
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-level reference model checked every clk, plus fixed scenario expectations.
module tb_i2s_tx;

    localparam int SW  = 16;
    localparam int SL  = 32;
    localparam int TPS = 4;
    localparam int FT  = 2 * SL * TPS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mclk_tick = 1'b0;
    logic          s_valid = 1'b0;
    logic [SW-1:0] s_left = '0;
    logic [SW-1:0] s_right = '0;
    logic          s_ready, i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdata, frame_start, underrun;

    i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .TPS(TPS)) dut (
        .clk         (clk),
        .rst         (rst),
        .mclk_tick   (mclk_tick),
        .s_valid     (s_valid),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_ready     (s_ready),
        .i2s_mclk    (i2s_mclk),
        .i2s_sclk    (i2s_sclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit stall = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Master-clock tick every 4th clk, suppressed while stalled.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (stall) mclk_tick = 1'b0;
            else begin
                mclk_tick = (ph == 3);
                ph = (ph + 1) % 4;
            end
        end
    end

    // Reference model: frame position counted in ticks, bit value computed from the slot rules.
    int            m_tcnt;
    bit            m_mclk, m_full, m_ready, m_fs, m_ur, m_sdata;
    logic [SW-1:0] m_bl, m_br, m_al, m_ar;

    function automatic bit exp_bit(input int t, input logic [SW-1:0] al, input logic [SW-1:0] ar);
        int b;
        logic [SW-1:0] s;
        b = (t / TPS) % SL;
        s = (t >= FT / 2) ? ar : al;
        if (b == 0 || b > SW) return 1'b0;
        return s[SW-b];
    endfunction

    initial begin
        bit acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_tcnt = 0; m_mclk = 0; m_full = 0; m_ready = 0;
                m_fs = 0; m_ur = 0; m_sdata = 0;
                m_bl = '0; m_br = '0; m_al = '0; m_ar = '0;
            end else begin
                acc  = s_valid && m_ready;
                m_fs = 0;
                m_ur = 0;
                if (mclk_tick) begin
                    if (m_tcnt == FT - 1) begin
                        m_fs = 1;
                        if (m_full) begin
                            m_al = m_bl; m_ar = m_br; m_full = 0;
                        end else begin
                            m_al = '0; m_ar = '0; m_ur = 1;
                        end
                    end
                    m_tcnt = (m_tcnt + 1) % FT;
                    m_mclk = !m_mclk;
                    if (m_tcnt % TPS == 0) m_sdata = exp_bit(m_tcnt, m_al, m_ar);
                end
                if (acc) begin
                    m_full = 1; m_bl = s_left; m_br = s_right;
                end
                m_ready = !m_full;
            end
            #1;
            check("mclk",        64'(i2s_mclk),    64'(m_mclk));
            check("sclk",        64'(i2s_sclk),    64'((m_tcnt % TPS) >= TPS / 2));
            check("lrck",        64'(i2s_lrck),    64'(m_tcnt >= FT / 2));
            check("sdata",       64'(i2s_sdata),   64'(m_sdata));
            check("frame_start", 64'(frame_start), 64'(m_fs));
            check("underrun",    64'(underrun),    64'(m_ur));
            check("s_ready",     64'(s_ready),     64'(m_ready));
        end
    end

    task automatic wait_fs();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (frame_start !== 1'b1 && n < 3000);
        if (frame_start !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_frame_start: got no pulse, expected one within 3000 clk");
        end
    endtask

    task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r,
                        output bit fs_seen, output bit ur_seen);
        int n = 0;
        bit done = 0;
        fs_seen = 0;
        ur_seen = 0;
        s_valid = 1'b1; s_left = l; s_right = r;
        while (!done && n < 3000) begin
            done    = (s_ready === 1'b1);
            fs_seen = frame_start;
            ur_seen = underrun;
            @(posedge clk);
            #2;
            n++;
        end
        s_valid = 1'b0; s_left = SW'($urandom); s_right = SW'($urandom);
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got no s_ready, expected acceptance within 3000 clk");
        end
    endtask

    initial begin
        bit fs_f, ur_f, prev;
        int cyc, lr_hi, nb;
        logic [63:0] bits;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Known pair ahead of the first wrap, then capture one frame at sclk rising edges.
        push(16'h8001, 16'h7FFE, fs_f, ur_f);
        wait_fs();
        check("first_wrap_underrun", 64'(underrun), 64'd0);
        cyc = 0; lr_hi = 0; nb = 0; bits = '0; prev = i2s_sclk;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (i2s_lrck) lr_hi++;
            if (i2s_sclk && !prev && nb < 64) begin
                bits = {bits[62:0], i2s_sdata};
                nb++;
            end
            prev = i2s_sclk;
        end while (frame_start !== 1'b1 && cyc < 3000);
        check("frame_bits",     bits,         64'h4000_8000_3FFF_0000);
        check("frame_period",   64'(cyc),     64'd1024);
        check("lrck_high_clks", 64'(lr_hi),   64'd512);
        check("empty_underrun", 64'(underrun), 64'd1);

        // Two pairs queued back to back: second goes in during the frame_start clk.
        push(SW'($urandom), SW'($urandom), fs_f, ur_f);
        push(SW'($urandom), SW'($urandom), fs_f, ur_f);
        check("second_accept_at_fs", 64'(fs_f), 64'd1);
        check("second_accept_no_ur", 64'(ur_f), 64'd0);

        // Offer a pair exactly on the wrap edge with the buffer empty.
        wait_fs();
        repeat (FT * TPS - 1) @(posedge clk);
        #2;
        s_valid = 1'b1; s_left = 16'h1234; s_right = 16'hABCD;
        @(posedge clk);
        #1;
        check("edge_fs",       64'(frame_start), 64'd1);
        check("edge_underrun", 64'(underrun),    64'd1);
        check("edge_taken",    64'(s_ready),     64'd0);
        #1 s_valid = 1'b0;
        wait_fs();
        check("edge_next_ur", 64'(underrun), 64'd0);

        // Random traffic with a mid-slot tick stall.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 1400)) @(posedge clk);
            #2;
            if (k == 3) begin
                repeat (37) @(posedge clk);
                #2 stall = 1'b1;
                repeat (100) @(posedge clk);
                #2 stall = 1'b0;
            end
            push(SW'($urandom), SW'($urandom), fs_f, ur_f);
        end

        // Reset in the middle of the right slot with a pair buffered.
        wait_fs();
        #1;
        push(SW'($urandom), SW'($urandom), fs_f, ur_f);
        cyc = 0;
        while (i2s_lrck !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pins",  64'({i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdata}), 64'd0);
        check("rst_pulse", 64'({frame_start, underrun}), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(s_ready), 64'd1);
        wait_fs();
        check("post_rst_discard", 64'(underrun), 64'd1);

        for (int k = 0; k < 3; k++) begin
            #1;
            push(SW'($urandom), SW'($urandom), fs_f, ur_f);
            repeat ($urandom_range(0, 600)) @(posedge clk);
        end
        wait_fs();
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
